alarm_bank: RTL and testbench

- Parametrised multi-alarm engine; successor to the single-alarm register-plus-compare arrangement in the clock top level.
- Holds NUM_ALARMS independently armed alarm times in 24-hour BCD and compares them with the running clock.
- Adds a snooze with configurable length and an automatic ring timeout.
- Runs entirely on one clock, using strobes (tick_1hz, tick_set, tick_beep) from the clock divider instead of derived clocks. Sits between the time register and the output wrapper.

---
 rtl/alarm_bank_pkg.sv | 45 ++++
 rtl/alarm_bank_bcd_time_add.sv | 30 +++
 rtl/alarm_bank.sv | 150 +++++++++++++++
 tb/tb_alarm_bank.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_bank_pkg.sv
// Shared types, BCD limits and BCD helper functions for the alarm bank.
package alarm_bank_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  // Increment a two-digit BCD value, wrapping to 00 once lim is reached.
  function automatic logic [7:0] bcd_inc_lim(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v >= lim)
      r = 8'h00;
    else if (v[3:0] == 4'h9)
      r = {v[7:4] + 4'h1, 4'h0};
    else
      r = {v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc_min(input logic [7:0] v);
    return bcd_inc_lim(v, MIN_MAX);
  endfunction

  function automatic logic [7:0] bcd_inc_hr(input logic [7:0] v);
    return bcd_inc_lim(v, HR_MAX);
  endfunction

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
    return ({4'h0, v[7:4]} * 8'd10) + {4'h0, v[3:0]};
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
    logic [7:0] t;
    logic [7:0] o;
    t = v / 8'd10;
    o = v - (t * 8'd10);
    return {t[3:0], o[3:0]};
  endfunction

endpackage

// File: rtl/alarm_bank_bcd_time_add.sv
// Combinational hours:minutes + ADD_MIN minutes in BCD, with hour carry and 24h wrap.
module bcd_time_add
  import alarm_bank_pkg::*;
#(
  parameter int ADD_MIN = 9
) (
  input  logic [7:0] hours,
  input  logic [7:0] minutes,
  output logic [7:0] sum_hours,
  output logic [7:0] sum_minutes
);

  logic [7:0] m_sum;
  logic [7:0] h_sum;

  // Add in binary, fold minutes past 59 into the hour, then wrap the day.
  always_comb begin
    m_sum = bcd_to_bin(minutes) + 8'(ADD_MIN);
    h_sum = bcd_to_bin(hours);
    if (m_sum >= 8'd60) begin
      m_sum = m_sum - 8'd60;
      h_sum = h_sum + 8'd1;
    end
    if (h_sum >= 8'd24)
      h_sum = h_sum - 8'd24;
    sum_hours   = bin_to_bcd(h_sum);
    sum_minutes = bin_to_bcd(m_sum);
  end

endmodule

// File: rtl/alarm_bank.sv
// Multi-alarm engine: settable BCD alarm registers, match detection,
// ring/snooze FSM with automatic timeout, and beeper/display-blank drive.
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter int NUM_ALARMS     = 4,
  parameter int SEL_W          = 2,
  parameter int SNOOZE_MIN     = 9,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_1hz,
  input  logic                  tick_set,
  input  logic                  tick_beep,
  input  logic [7:0]            clock_hours,
  input  logic [7:0]            clock_minutes,
  input  logic [7:0]            clock_seconds,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  set_mode,
  input  logic                  set_hours,
  input  logic                  set_minutes,
  input  logic [NUM_ALARMS-1:0] arm_en,
  input  logic                  snooze,
  input  logic                  alarm_reset,
  output logic [7:0]            disp_hours,
  output logic [7:0]            disp_minutes,
  output logic                  ringing,
  output logic                  snoozed,
  output logic [SEL_W-1:0]      ring_id,
  output logic                  beep,
  output logic                  output_en
);

  localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);

  logic [7:0]       alarm_hr  [NUM_ALARMS];
  logic [7:0]       alarm_min [NUM_ALARMS];
  state_t           state;
  state_t           state_next;
  logic [7:0]       ring_cnt;
  logic [7:0]       tgt_hours;
  logic [7:0]       tgt_minutes;
  logic [7:0]       snz_hours;
  logic [7:0]       snz_minutes;
  logic             match;
  logic [SEL_W-1:0] match_id;
  logic             armed_cur;
  logic             minute_edge;
  logic             snooze_hit;

  bcd_time_add #(.ADD_MIN(SNOOZE_MIN)) u_snooze_add (
    .hours       (clock_hours),
    .minutes     (clock_minutes),
    .sum_hours   (snz_hours),
    .sum_minutes (snz_minutes)
  );

  // Alarm registers; a select with no matching entry writes nothing.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (!rst_n) begin
        alarm_hr[k]  <= 8'h00;
        alarm_min[k] <= 8'h00;
      end else if (set_mode && tick_set && (sel == SEL_W'(k))) begin
        if (set_hours)   alarm_hr[k]  <= bcd_inc_hr(alarm_hr[k]);
        if (set_minutes) alarm_min[k] <= bcd_inc_min(alarm_min[k]);
      end
    end
  end

  // Display mux, match search (lowest index wins) and armed status of the active alarm.
  always_comb begin
    disp_hours   = 8'h00;
    disp_minutes = 8'h00;
    match        = 1'b0;
    match_id     = '0;
    armed_cur    = 1'b0;
    minute_edge  = tick_1hz && (clock_seconds == 8'h00);
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (sel == SEL_W'(k)) begin
        disp_hours   = alarm_hr[k];
        disp_minutes = alarm_min[k];
      end
      if (ring_id == SEL_W'(k))
        armed_cur = arm_en[k];
      if (minute_edge && arm_en[k] && (clock_hours == alarm_hr[k]) &&
          (clock_minutes == alarm_min[k])) begin
        match    = 1'b1;
        match_id = SEL_W'(k);
      end
    end
    snooze_hit = minute_edge && (clock_hours == tgt_hours) && (clock_minutes == tgt_minutes);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (match) state_next = RINGING;
      RINGING: begin
        if (!armed_cur || alarm_reset)              state_next = IDLE;
        else if (snooze)                            state_next = SNOOZED;
        else if (tick_1hz && (ring_cnt == RING_LAST)) state_next = IDLE;
      end
      SNOOZED: begin
        if (alarm_reset || !armed_cur) state_next = IDLE;
        else if (snooze_hit)           state_next = RINGING;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ring bookkeeping: active ID, seconds rung, snooze target and beeper toggle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ring_id     <= '0;
      ring_cnt    <= 8'd0;
      tgt_hours   <= 8'h00;
      tgt_minutes <= 8'h00;
      beep        <= 1'b0;
    end else begin
      if ((state == IDLE) && match)
        ring_id <= match_id;
      if ((state != RINGING) || (state_next != RINGING))
        ring_cnt <= 8'd0;
      else if (tick_1hz)
        ring_cnt <= ring_cnt + 8'd1;
      if ((state == RINGING) && (state_next == SNOOZED)) begin
        tgt_hours   <= snz_hours;
        tgt_minutes <= snz_minutes;
      end
      beep <= ((state == RINGING) && (state_next == RINGING)) ? (beep ^ tick_beep) : 1'b0;
    end
  end

  // FSM outputs; the display blanks in step with the beeper while ringing.
  always_comb begin
    ringing   = (state == RINGING);
    snoozed   = (state == SNOOZED);
    output_en = !(ringing && beep);
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed self-checking bench for alarm_bank.
module tb_alarm_bank;

  logic       clk = 1'b0;
  logic       rst_n, tick_1hz, tick_set, tick_beep;
  logic [7:0] clock_hours, clock_minutes, clock_seconds;
  logic [1:0] sel;
  logic       set_mode, set_hours, set_minutes;
  logic [3:0] arm_en;
  logic       snooze, alarm_reset;
  logic [7:0] disp_hours, disp_minutes;
  logic       ringing, snoozed, beep, output_en;
  logic [1:0] ring_id;

  int n_chk  = 0;
  int n_pass = 0;

  alarm_bank #(.NUM_ALARMS(4), .SEL_W(2), .SNOOZE_MIN(9), .RING_TIMEOUT_S(60)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_set(tick_set), .tick_beep(tick_beep),
    .clock_hours(clock_hours), .clock_minutes(clock_minutes), .clock_seconds(clock_seconds),
    .sel(sel), .set_mode(set_mode), .set_hours(set_hours), .set_minutes(set_minutes),
    .arm_en(arm_en), .snooze(snooze), .alarm_reset(alarm_reset),
    .disp_hours(disp_hours), .disp_minutes(disp_minutes), .ringing(ringing), .snoozed(snoozed),
    .ring_id(ring_id), .beep(beep), .output_en(output_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tick(input logic h, input logic m);
    set_hours = h; set_minutes = m; tick_set = 1'b1;
    step();
    tick_set = 1'b0; set_hours = 1'b0; set_minutes = 1'b0;
  endtask

  task automatic set_alarm(input logic [1:0] s, input int nh, input int nm);
    set_mode = 1'b1; sel = s;
    for (int i = 0; i < nh; i++) set_tick(1'b1, 1'b0);
    for (int i = 0; i < nm; i++) set_tick(1'b0, 1'b1);
    set_mode = 1'b0;
  endtask

  task automatic sec_tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    clock_hours = h; clock_minutes = m; clock_seconds = s; tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic beep_tick();
    tick_beep = 1'b1;
    step();
    tick_beep = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; tick_set = 1'b0; tick_beep = 1'b0;
    clock_hours = 8'h00; clock_minutes = 8'h00; clock_seconds = 8'h00;
    sel = 2'd0; set_mode = 1'b0; set_hours = 1'b0; set_minutes = 1'b0;
    arm_en = 4'b0000; snooze = 1'b0; alarm_reset = 1'b0;
    step(); step();
    chk("rst_ringing", ringing, 0);
    chk("rst_snoozed", snoozed, 0);
    chk("rst_beep", beep, 0);
    chk("rst_oe", output_en, 1);
    chk("rst_id", ring_id, 0);
    chk("rst_disp", {disp_hours, disp_minutes}, 16'h0000);
    rst_n = 1'b1;
    step();

    // minutes wrap with no hour carry
    set_mode = 1'b1; sel = 2'd1;
    for (int i = 0; i < 61; i++) begin
      set_tick(1'b0, 1'b1);
      if (i == 58) chk("min_59", disp_minutes, 8'h59);
    end
    chk("min_wrap", {disp_hours, disp_minutes}, 16'h0001);
    for (int i = 0; i < 24; i++) begin
      set_tick(1'b1, 1'b0);
      if (i == 22) chk("hr_23", disp_hours, 8'h23);
    end
    chk("hr_wrap", {disp_hours, disp_minutes}, 16'h0001);
    sel = 2'd0;
    #1 chk("sel0_untouched", {disp_hours, disp_minutes}, 16'h0000);
    sel = 2'd3;
    set_tick(1'b1, 1'b1);
    chk("both_inc", {disp_hours, disp_minutes}, 16'h0101);
    set_mode = 1'b0;

    set_alarm(2'd2, 7, 30);
    chk("alarm2", {disp_hours, disp_minutes}, 16'h0730);

    // match requires arm, tick and seconds 00
    sec_tick(8'h07, 8'h30, 8'h00);
    chk("no_arm", ringing, 0);
    arm_en = 4'b0100;
    clock_seconds = 8'h00;
    step();
    chk("no_tick", ringing, 0);
    sec_tick(8'h07, 8'h30, 8'h01);
    chk("sec_nz", ringing, 0);
    sec_tick(8'h07, 8'h30, 8'h00);
    chk("ring", ringing, 1);
    chk("ring_id2", ring_id, 2);
    chk("ring_beep0", beep, 0);
    beep_tick();
    chk("beep_on", beep, 1);
    chk("oe_blank", output_en, 0);
    beep_tick();
    chk("beep_off", beep, 0);
    chk("oe_on", output_en, 1);
    beep_tick();

    // timeout after 60 seconds of ringing
    for (int i = 0; i < 59; i++) sec_tick(8'h07, 8'h30, 8'h01);
    chk("still_ring", ringing, 1);
    chk("still_beep", beep, 1);
    sec_tick(8'h07, 8'h30, 8'h02);
    chk("timeout", ringing, 0);
    chk("timeout_beep", beep, 0);
    chk("timeout_oe", output_en, 1);

    // snooze across midnight
    sec_tick(8'h07, 8'h30, 8'h00);
    chk("ring2", ringing, 1);
    beep_tick();
    clock_hours = 8'h23; clock_minutes = 8'h55; snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snoozed", snoozed, 1);
    chk("snz_ringing", ringing, 0);
    chk("snz_beep", beep, 0);
    chk("snz_oe", output_en, 1);
    sec_tick(8'h00, 8'h03, 8'h00);
    chk("snz_early", snoozed, 1);
    sec_tick(8'h00, 8'h04, 8'h01);
    chk("snz_sec", snoozed, 1);
    sec_tick(8'h00, 8'h04, 8'h00);
    chk("snz_ring", ringing, 1);
    chk("snz_id", ring_id, 2);
    alarm_reset = 1'b1;
    step();
    alarm_reset = 1'b0;
    chk("areset", ringing, 0);

    // lowest index wins; reset beats snooze; disarm while snoozed
    set_alarm(2'd0, 6, 0);
    set_alarm(2'd3, 5, 59);
    chk("alarm3", {disp_hours, disp_minutes}, 16'h0600);
    arm_en = 4'b1001;
    sec_tick(8'h06, 8'h00, 8'h00);
    chk("multi_id", ring_id, 0);
    chk("multi_ring", ringing, 1);
    snooze = 1'b1; alarm_reset = 1'b1;
    step();
    snooze = 1'b0; alarm_reset = 1'b0;
    chk("rst_wins_r", ringing, 0);
    chk("rst_wins_s", snoozed, 0);
    sec_tick(8'h06, 8'h00, 8'h00);
    chk("ring3", ringing, 1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snoozed2", snoozed, 1);
    sec_tick(8'h06, 8'h00, 8'h00);
    chk("snz_ignore", {ringing, snoozed}, 2'b01);
    arm_en = 4'b1000;
    step();
    chk("disarm_snz", {ringing, snoozed}, 2'b00);

    // disarm while ringing, then reset mid-ring
    sec_tick(8'h06, 8'h00, 8'h00);
    chk("ring_id3", ring_id, 3);
    arm_en = 4'b0000;
    step();
    chk("disarm_ring", ringing, 0);
    arm_en = 4'b1000;
    sec_tick(8'h06, 8'h00, 8'h00);
    beep_tick();
    chk("pre_rst_beep", beep, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sel = 2'd3;
    #1;
    chk("mid_rst_ring", ringing, 0);
    chk("mid_rst_beep", beep, 0);
    chk("mid_rst_oe", output_en, 1);
    chk("mid_rst_id", ring_id, 0);
    chk("mid_rst_disp", {disp_hours, disp_minutes}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
